// File: rtl/bmsce_mux_arbiter.sv
// rtl/bmsce_mux_arbiter.sv - two-requester arbiter driving a registered 2:1 mux select
// Round-robin or fixed-priority-A grant with a hold limit that forces rotation under contention.
module bmsce_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic       last_b, last_b_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic       sel, sel_nxt;
    logic       other_req;

    logic req_a, req_b, data_a, data_b, mode;
    assign req_a  = ui_in[0];
    assign req_b  = ui_in[1];
    assign data_a = ui_in[2];
    assign data_b = ui_in[3];
    assign mode   = ui_in[4];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && !req_b)
                    state_nxt = GNT_A;
                else if (req_b && !req_a)
                    state_nxt = GNT_B;
                else if (req_a && req_b)
                    state_nxt = (mode || last_b) ? GNT_A : GNT_B;
            end
            GNT_A: begin
                if (!req_a)
                    state_nxt = req_b ? GNT_B : IDLE;
                else if (req_b && hold_cnt == HOLD_LAST)
                    state_nxt = GNT_B;
            end
            GNT_B: begin
                if (!req_b)
                    state_nxt = req_a ? GNT_A : IDLE;
                else if (req_a && hold_cnt == HOLD_LAST)
                    state_nxt = GNT_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold counter only advances while the opposite side is actually waiting.
    assign other_req = (state == GNT_A) ? req_b : req_a;

    always_comb begin
        hold_nxt = hold_cnt;
        if (state_nxt != state || state_nxt == IDLE)
            hold_nxt = 4'd0;
        else if (other_req && hold_cnt != HOLD_LAST)
            hold_nxt = hold_cnt + 4'd1;
    end

    always_comb begin
        last_b_nxt = last_b;
        sel_nxt    = sel;
        if (state_nxt == GNT_A) begin
            last_b_nxt = 1'b0;
            sel_nxt    = 1'b1;
        end else if (state_nxt == GNT_B) begin
            last_b_nxt = 1'b1;
            sel_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            hold_cnt <= 4'd0;
            sel      <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            hold_cnt <= hold_nxt;
            sel      <= sel_nxt;
        end
    end

    logic gnt_a, gnt_b, y;
    assign gnt_a = (state == GNT_A);
    assign gnt_b = (state == GNT_B);
    assign y     = gnt_a ? data_a : (gnt_b ? data_b : 1'b0);

    assign uo_out  = {hold_cnt, sel, gnt_b, gnt_a, y};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    wire _unused = &{1'b0, ena, ui_in[7:5], uio_in};

endmodule

// File: tb/tb_bmsce_mux_arbiter.sv
// tb/tb_bmsce_mux_arbiter.sv - scoreboard bench for bmsce_mux_arbiter
module tb_bmsce_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    bmsce_mux_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [23:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got oe/out/uo=%06h want %06h", name, act, want);
        end
    endtask

    // ex(y, gnt_a, gnt_b, sel, hold) -> expected uo_out
    function automatic logic [7:0] ex(input logic y, input logic ga, input logic gb,
                                      input logic s, input int h);
        return {4'(h), s, gb, ga, y};
    endfunction

    task automatic step(input logic [7:0] ui, input logic [7:0] want);
        exp_t e;
        @(negedge clk);
        ui_in = ui;
        e.idx = vec_idx;
        e.val = {16'h0000, want};
        exp_q.push_back(e);
        vec_idx++;
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d", e.idx), {uio_oe, uio_out, uo_out}, e.val);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 24'(exp_q.size()), 24'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'hA5;
        #3;
        check("reset_async", {uio_oe, uio_out, uo_out}, 24'h0);
        #14;
        check("reset_after_edge", {uio_oe, uio_out, uo_out}, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // req_a only, data toggling; data_b noise must not leak into y
        step(8'h05, ex(1, 1, 0, 1, 0));
        step(8'h09, ex(0, 1, 0, 1, 0));
        step(8'h05, ex(1, 1, 0, 1, 0));
        step(8'h01, ex(0, 1, 0, 1, 0));
        step(8'h00, ex(0, 0, 0, 1, 0));

        // mode=1 with last winner A: A still wins, forced rotation after 8 cycles
        for (int k = 1; k <= 8; k++) step(8'h17, ex(1, 1, 0, 1, k - 1));
        step(8'h17, ex(0, 0, 1, 0, 0));
        step(8'h17, ex(0, 0, 1, 0, 1));
        // drop both in GNT_B: IDLE, sel stays 0
        step(8'h00, ex(0, 0, 0, 0, 0));

        // reach GNT_B then reset between edges
        step(8'h0A, ex(1, 0, 1, 0, 0));
        step(8'h0A, ex(1, 0, 1, 0, 0));
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_gnt_b", {uio_oe, uio_out, uo_out}, 24'h0);
        ui_in = 8'h00;
        @(negedge clk);
        check("reset_held", {uio_oe, uio_out, uo_out}, 24'h0);
        rst_n = 1'b1;

        // mode=0 contention after reset: A first, alternate every 8 cycles
        for (int k = 1; k <= 8; k++) step(8'h0B, ex(0, 1, 0, 1, k - 1));
        for (int k = 1; k <= 8; k++) step(8'h0B, ex(1, 0, 1, 0, k - 1));
        step(8'h0B, ex(0, 1, 0, 1, 0));
        step(8'h0B, ex(0, 1, 0, 1, 1));
        // drop req_a with req_b up: straight to GNT_B, no idle gap
        step(8'h0A, ex(1, 0, 1, 0, 0));
        step(8'h00, ex(0, 0, 0, 0, 0));
        // round-robin tie with last winner B goes to A
        step(8'h03, ex(0, 1, 0, 1, 0));
        step(8'h00, ex(0, 0, 0, 1, 0));

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
